// File: rtl/mmio_dma.sv
// mmio_dma: bus-initiator block copier for the MMIO data-memory/IO bus.
// Copies len 32-bit words from src to dst in ascending order, taking one word
// every two cycles (a READ cycle followed by a WRITE cycle).
// The responder's read path is combinational and it writes on the rising edge.
// Optional build macro MMIO_DMA_FIXED_SRC_EN adds the src_fixed input. When it
// is set at start, the source address stays put so a single IO port can be
// drained into memory.
module mmio_dma #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic [AW-1:0]   src,
  input  logic [AW-1:0]   dst,
  input  logic [LENW-1:0] len,
`ifdef MMIO_DMA_FIXED_SRC_EN
  input  logic            src_fixed,
`endif
  output logic            busy,
  output logic            done,
  output logic [LENW-1:0] words_left,
  output logic            mem_we,
  output logic [AW-1:0]   mem_a,
  output logic [DW-1:0]   mem_wd,
  input  logic [DW-1:0]   mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   srcPtr_q, srcPtr_d;
  logic [AW-1:0]   dstPtr_q, dstPtr_d;
  logic [DW-1:0]   buffer_q, buffer_d;
  logic [LENW-1:0] wordsLeft_q, wordsLeft_d;
  logic [AW-1:0]   srcStep;

  // The two low address bits are word-aligned away and never used.
  logic            unusedAddrBits;
  assign unusedAddrBits = ^{src[1:0], dst[1:0]};

`ifdef MMIO_DMA_FIXED_SRC_EN
  logic srcFixed_q, srcFixed_d;

  // A latched fixed-source request stops the source pointer from advancing.
  assign srcStep = srcFixed_q ? '0 : AW'(4);
`else
  assign srcStep = AW'(4);
`endif

  // State and datapath registers. Reset clears everything, so an in-flight
  // transfer stops at once and issues no further writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      srcPtr_q    <= '0;
      dstPtr_q    <= '0;
      buffer_q    <= '0;
      wordsLeft_q <= '0;
    end else begin
      state_q     <= state_d;
      srcPtr_q    <= srcPtr_d;
      dstPtr_q    <= dstPtr_d;
      buffer_q    <= buffer_d;
      wordsLeft_q <= wordsLeft_d;
    end
  end

`ifdef MMIO_DMA_FIXED_SRC_EN
  // Holds the fixed-source mode for the whole transfer. It is captured with
  // the pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srcFixed_q <= 1'b0;
    end else begin
      srcFixed_q <= srcFixed_d;
    end
  end
`endif

  // Next-state logic and bus outputs. The bus is driven only in READ and
  // WRITE. abort kills the pending write in the same cycle.
  always_comb begin
    state_d     = state_q;
    srcPtr_d    = srcPtr_q;
    dstPtr_d    = dstPtr_q;
    buffer_d    = buffer_q;
    wordsLeft_d = wordsLeft_q;
`ifdef MMIO_DMA_FIXED_SRC_EN
    srcFixed_d  = srcFixed_q;
`endif
    busy        = 1'b0;
    done        = 1'b0;
    mem_we      = 1'b0;
    mem_a       = '0;
    mem_wd      = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          srcPtr_d    = {src[AW-1:2], 2'b00};
          dstPtr_d    = {dst[AW-1:2], 2'b00};
          wordsLeft_d = len;
`ifdef MMIO_DMA_FIXED_SRC_EN
          srcFixed_d  = src_fixed;
`endif
          state_d     = (len != '0) ? READ : DONE;
        end
      end

      READ: begin
        busy  = 1'b1;
        mem_a = srcPtr_q;
        if (abort) begin
          state_d = IDLE;
        end else begin
          buffer_d = mem_rd;
          state_d  = WRITE;
        end
      end

      WRITE: begin
        busy   = 1'b1;
        mem_a  = dstPtr_q;
        mem_wd = buffer_q;
        mem_we = !abort;
        if (abort) begin
          state_d = IDLE;
        end else begin
          srcPtr_d    = srcPtr_q + srcStep;
          dstPtr_d    = dstPtr_q + AW'(4);
          wordsLeft_d = wordsLeft_q - LENW'(1);
          state_d     = (wordsLeft_q == LENW'(1)) ? DONE : READ;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign words_left = wordsLeft_q;

endmodule

// File: tb/tb_mmio_dma.sv
// tb_mmio_dma: directed self-checking bench for mmio_dma.
// A small word memory serves as the bus responder. It reads combinationally and
// writes on the rising edge. Port B at 0x7F10 can auto-advance after each read.
// Define MMIO_DMA_FIXED_SRC_EN to also cover the fixed-source mode.
module tb_mmio_dma;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [15:0] len = '0;
  logic        srcFixed = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] wordsLeft;
  logic        memWe;
  logic [31:0] memA;
  logic [31:0] memWd;
  logic [31:0] memRd;

  // Responder memory, preload port and port B auto-advance control.
  logic [31:0] ram [0:1023];
  logic        loadEn = 1'b0;
  logic [31:0] loadAddr = '0;
  logic [31:0] loadData = '0;
  logic        portBInc = 1'b0;

  // Bus monitors.
  logic        clrMon = 1'b0;
  int          busyCnt;
  int          doneCnt;
  int          weCnt;
  int          badReadCnt;
  logic [31:0] lastWrA;
  logic [31:0] lastWrD;

  int          total = 0;
  int          bad = 0;
  int          edges;

  mmio_dma dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .src        (src),
    .dst        (dst),
    .len        (len),
`ifdef MMIO_DMA_FIXED_SRC_EN
    .src_fixed  (srcFixed),
`endif
    .busy       (busy),
    .done       (done),
    .words_left (wordsLeft),
    .mem_we     (memWe),
    .mem_a      (memA),
    .mem_wd     (memWd),
    .mem_rd     (memRd)
  );

  always #5 clk = ~clk;

  // Maps each address used here to a distinct slot of the model memory.
  function automatic logic [9:0] keyOf(input logic [31:0] a);
    return {a[15:12], a[7:2]};
  endfunction

  assign memRd = ram[keyOf(memA)];

  // Responder: preload writes, bus writes, and port B advancing after a read.
  always @(posedge clk) begin
    if (loadEn) begin
      ram[keyOf(loadAddr)] <= loadData;
    end else begin
      if (memWe) ram[keyOf(memA)] <= memWd;
      if (portBInc && busy && !memWe && memA == 32'h0000_7F10)
        ram[keyOf(32'h0000_7F10)] <= ram[keyOf(32'h0000_7F10)] + 32'd1;
    end
  end

  // Mid-cycle monitor of busy/done/write activity and of read addresses.
  always @(negedge clk) begin
    if (clrMon) begin
      busyCnt    <= 0;
      doneCnt    <= 0;
      weCnt      <= 0;
      badReadCnt <= 0;
      lastWrA    <= '0;
      lastWrD    <= '0;
    end else begin
      if (busy) busyCnt <= busyCnt + 1;
      if (done) doneCnt <= doneCnt + 1;
      if (memWe) begin
        weCnt   <= weCnt + 1;
        lastWrA <= memA;
        lastWrD <= memWd;
      end
      if (portBInc && busy && !memWe && memA != 32'h0000_7F10)
        badReadCnt <= badReadCnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic pokeWord(input logic [31:0] a, input logic [31:0] d);
    loadAddr = a;
    loadData = d;
    loadEn   = 1'b1;
    @(posedge clk);
    #1 loadEn = 1'b0;
  endtask

  task automatic clearMonitors();
    clrMon = 1'b1;
    @(negedge clk);
    #1 clrMon = 1'b0;
  endtask

  // Presents a request and holds start across exactly one rising edge.
  task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d,
                               input logic [15:0] l);
    src   = s;
    dst   = d;
    len   = l;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges until done is seen; -1 means it never came.
  task automatic waitDone(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  // Lets the current cycle's negedge monitor sample, then moves on one edge.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_we", 32'(memWe), 32'd0);
    checkOutput("rst_mem_a", memA, 32'd0);
    checkOutput("rst_mem_wd", memWd, 32'd0);
    checkOutput("rst_words_left", 32'(wordsLeft), 32'd0);
    #9 reset_n = 1'b1;
    settle();

    // Four-word copy RAM to RAM
    pokeWord(32'h1000, 32'd1);
    pokeWord(32'h1004, 32'd2);
    pokeWord(32'h1008, 32'd3);
    pokeWord(32'h100C, 32'd4);
    for (int i = 0; i < 4; i++) pokeWord(32'h1020 + 32'(4 * i), 32'h0);
    clearMonitors();
    applyStimulus(32'h1000, 32'h1020, 16'd4);
    waitDone(edges);
    checkOutput("t1_done_edge", 32'(edges), 32'd8);
    settle();
    checkOutput("t1_busy_cycles", 32'(busyCnt), 32'd8);
    checkOutput("t1_done_cycles", 32'(doneCnt), 32'd1);
    checkOutput("t1_we_cycles", 32'(weCnt), 32'd4);
    checkOutput("t1_words_left", 32'(wordsLeft), 32'd0);
    checkOutput("t1_ram1020", ram[keyOf(32'h1020)], 32'd1);
    checkOutput("t1_ram1024", ram[keyOf(32'h1024)], 32'd2);
    checkOutput("t1_ram1028", ram[keyOf(32'h1028)], 32'd3);
    checkOutput("t1_ram102C", ram[keyOf(32'h102C)], 32'd4);

    // Single word to port C
    pokeWord(32'h1000, 32'h0000_ABCD);
    pokeWord(32'h7F20, 32'h0);
    clearMonitors();
    applyStimulus(32'h1000, 32'h7F20, 16'd1);
    waitDone(edges);
    checkOutput("t2_done_edge", 32'(edges), 32'd2);
    settle();
    checkOutput("t2_we_cycles", 32'(weCnt), 32'd1);
    checkOutput("t2_wr_addr", lastWrA, 32'h0000_7F20);
    checkOutput("t2_wr_data", lastWrD, 32'h0000_ABCD);
    checkOutput("t2_portC", ram[keyOf(32'h7F20)], 32'h0000_ABCD);

    // Zero-length request
    clearMonitors();
    applyStimulus(32'h1000, 32'h1020, 16'd0);
    checkOutput("t3_done_now", 32'(done), 32'd1);
    settle();
    settle();
    checkOutput("t3_we_cycles", 32'(weCnt), 32'd0);
    checkOutput("t3_busy_cycles", 32'(busyCnt), 32'd0);
    checkOutput("t3_done_cycles", 32'(doneCnt), 32'd1);

    // Abort in the second WRITE of a three-word copy
    pokeWord(32'h1000, 32'd1);
    pokeWord(32'h3000, 32'hDEAD);
    pokeWord(32'h3004, 32'hDEAD);
    pokeWord(32'h3008, 32'hDEAD);
    clearMonitors();
    applyStimulus(32'h1000, 32'h3000, 16'd3);
    settle();
    settle();
    settle();
    checkOutput("t4_in_write", 32'(memA), 32'h3004);
    abort = 1'b1;
    #1;
    checkOutput("t4_abort_we", 32'(memWe), 32'd0);
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("t4_idle_busy", 32'(busy), 32'd0);
    checkOutput("t4_idle_mem_a", memA, 32'd0);
    checkOutput("t4_words_left", 32'(wordsLeft), 32'd2);
    settle();
    settle();
    settle();
    checkOutput("t4_no_done", 32'(doneCnt), 32'd0);
    checkOutput("t4_we_cycles", 32'(weCnt), 32'd1);
    checkOutput("t4_ram3000", ram[keyOf(32'h3000)], 32'd1);
    checkOutput("t4_ram3004", ram[keyOf(32'h3004)], 32'hDEAD);
    checkOutput("t4_words_hold", 32'(wordsLeft), 32'd2);

    // Source pointer wrap, with a start pulse ignored while busy
    pokeWord(32'hFFFF_FFFC, 32'h11);
    pokeWord(32'h0000_0000, 32'h22);
    pokeWord(32'h2000, 32'h0);
    pokeWord(32'h2004, 32'h0);
    clearMonitors();
    applyStimulus(32'hFFFF_FFFC, 32'h2000, 16'd2);
    checkOutput("t5_read0_addr", memA, 32'hFFFF_FFFC);
    applyStimulus(32'h1000, 32'h1020, 16'd4);
    checkOutput("t5_write0_addr", memA, 32'h2000);
    checkOutput("t5_len_kept", 32'(wordsLeft), 32'd2);
    settle();
    checkOutput("t5_wrap_addr", memA, 32'h0000_0000);
    checkOutput("t5_wrap_read_we", 32'(memWe), 32'd0);
    waitDone(edges);
    checkOutput("t5_done_edge", 32'(edges), 32'd2);
    settle();
    checkOutput("t5_ram2000", ram[keyOf(32'h2000)], 32'h11);
    checkOutput("t5_ram2004", ram[keyOf(32'h2004)], 32'h22);
    checkOutput("t5_we_cycles", 32'(weCnt), 32'd2);
    settle();
    checkOutput("t5_stays_idle", 32'(busy), 32'd0);

`ifdef MMIO_DMA_FIXED_SRC_EN
    // Fixed source draining port B into RAM
    pokeWord(32'h7F10, 32'd5);
    for (int i = 0; i < 3; i++) pokeWord(32'h4000 + 32'(4 * i), 32'h0);
    clearMonitors();
    portBInc = 1'b1;
    srcFixed = 1'b1;
    applyStimulus(32'h7F10, 32'h4000, 16'd3);
    srcFixed = 1'b0;
    waitDone(edges);
    checkOutput("fx_done_edge", 32'(edges), 32'd6);
    settle();
    portBInc = 1'b0;
    checkOutput("fx_bad_reads", 32'(badReadCnt), 32'd0);
    checkOutput("fx_ram4000", ram[keyOf(32'h4000)], 32'd5);
    checkOutput("fx_ram4004", ram[keyOf(32'h4004)], 32'd6);
    checkOutput("fx_ram4008", ram[keyOf(32'h4008)], 32'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
